// File: rtl/pacote_tomasulo.sv
// Constants shared by the Tomasulo core: station tags, tag width and the "no value" marker.
package pacote_tomasulo;

    localparam int unsigned TAG_W = 3;

    localparam logic [TAG_W-1:0] FREE_REGISTER    = 3'd0;
    localparam logic [TAG_W-1:0] RES_STATION_ADD1 = 3'd1;
    localparam logic [TAG_W-1:0] RES_STATION_ADD2 = 3'd2;
    localparam logic [TAG_W-1:0] RES_STATION_MUL1 = 3'd3;

    localparam logic [15:0] VALOR_VAZIO = 16'hFFF0;

endpackage

// File: rtl/arbitro_cdb_if.sv
// Request/result bundle between the reservation stations and the CDB arbiter.
interface arbitro_cdb_if #(
    parameter int unsigned N_RS   = 3,
    parameter int unsigned DATA_W = 16,
    parameter int unsigned TAG_W  = 3
);

    logic [N_RS-1:0]        req;
    logic [N_RS*DATA_W-1:0] req_data;
    logic                   hold_cdb;
    logic [N_RS-1:0]        ack;
    logic                   cdb_valid;
    logic [TAG_W-1:0]       cdb_tag;
    logic [DATA_W-1:0]      cdb_data;

    modport master (
        output req, req_data, hold_cdb,
        input  ack, cdb_valid, cdb_tag, cdb_data
    );

    modport slave (
        input  req, req_data, hold_cdb,
        output ack, cdb_valid, cdb_tag, cdb_data
    );

endinterface

// File: rtl/seletor_round_robin.sv
// Circular priority search: first set bit of elig starting at ptr, wrapping modulo N_RS.
module seletor_round_robin #(
    parameter int unsigned N_RS  = 3,
    parameter int unsigned PTR_W = (N_RS > 1) ? $clog2(N_RS) : 1
) (
    input  logic [N_RS-1:0]  elig,
    input  logic [PTR_W-1:0] ptr,
    output logic             found,
    output logic [PTR_W-1:0] winner
);

    logic [31:0] idx;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int unsigned k = 0; k < N_RS; k++) begin
            idx = 32'(ptr) + k;
            // N_RS need not be a power of two, so wrap with a compare instead of masking
            if (idx >= N_RS) begin
                idx = idx - N_RS;
            end
            if (!found && elig[PTR_W'(idx)]) begin
                found  = 1'b1;
                winner = PTR_W'(idx);
            end
        end
    end

endmodule

// File: rtl/arbitro_cdb.sv
// Round-robin CDB arbiter: grants one finished reservation station per cycle and broadcasts it.
module arbitro_cdb
    import pacote_tomasulo::*;
#(
    parameter int unsigned N_RS   = 3,
    parameter int unsigned DATA_W = 16
) (
    input logic          clock,
    input logic          reset,
    arbitro_cdb_if.slave bus
);

    localparam int unsigned PTR_W = (N_RS > 1) ? $clog2(N_RS) : 1;

    logic [PTR_W-1:0]  ptr_q;
    logic [N_RS-1:0]   ack_q;
    logic              valid_q;
    logic [TAG_W-1:0]  tag_q;
    logic [DATA_W-1:0] data_q;

    logic [N_RS-1:0]   elig;
    logic              found;
    logic [PTR_W-1:0]  winner;
    logic              grant;
    logic [PTR_W-1:0]  ptr_next;
    logic [DATA_W-1:0] win_data;

    // A station acked this cycle is masked so its result is never broadcast twice
    assign elig = bus.req & ~ack_q;

    seletor_round_robin #(
        .N_RS  (N_RS),
        .PTR_W (PTR_W)
    ) u_seletor (
        .elig   (elig),
        .ptr    (ptr_q),
        .found  (found),
        .winner (winner)
    );

    assign grant    = found & ~bus.hold_cdb;
    assign ptr_next = (32'(winner) == N_RS - 1) ? '0 : winner + PTR_W'(1);
    assign win_data = bus.req_data[32'(winner)*DATA_W +: DATA_W];

    always_ff @(posedge clock) begin
        if (!reset) begin
            ptr_q   <= '0;
            ack_q   <= '0;
            valid_q <= 1'b0;
            tag_q   <= FREE_REGISTER;
            data_q  <= DATA_W'(VALOR_VAZIO);
        end else if (grant) begin
            ptr_q   <= ptr_next;
            ack_q   <= N_RS'(1) << winner;
            valid_q <= 1'b1;
            tag_q   <= TAG_W'(winner) + TAG_W'(1);
            data_q  <= win_data;
        end else begin
            ack_q   <= '0;
            valid_q <= 1'b0;
            tag_q   <= FREE_REGISTER;
            data_q  <= DATA_W'(VALOR_VAZIO);
        end
    end

    assign bus.ack       = ack_q;
    assign bus.cdb_valid = valid_q;
    assign bus.cdb_tag   = tag_q;
    assign bus.cdb_data  = data_q;

endmodule

// File: doc/arbitro_cdb.md
# arbitro_cdb

Round-robin arbiter for the Common Data Bus (CDB) of the Tomasulo core. The reservation stations fed by the dispatch unit (ADD1, ADD2, MUL1) finish execution and request the CDB. The arbiter grants at most one request per cycle and broadcasts the winner's result with its station tag. The register status table and waiting reservation stations snoop that broadcast to resolve their pending Qj/Qk tags.

## Interface

- N_RS, 3: number of requesting reservation stations. Index i owns station tag i+1.
- DATA_W, 16: result width.
- TAG_W, 3: station tag width. Tag 0 means no station (free register).
- Clock  input  1: single clock, rising edge.
- Reset  input  1: synchronous, active-low. Sampled on the rising edge of Clock.
- Req  input  N_RS: Req[i] high means station i holds a finished result.
- Req_Data  input  N_RS*DATA_W: result of station i in bits [i*DATA_W +: DATA_W]. Held stable while Req[i] is high.
- Hold_CDB  input  1: register-file write port busy. Suppresses any new grant this cycle.
- Ack  output  N_RS: one-hot, registered. Ack[i] high for one cycle means station i's result is on the CDB this cycle.
- CDB_Valid  output  1: registered. Broadcast valid.
- CDB_Tag  output  TAG_W: registered. Producing station tag (winner index + 1).
- CDB_Data  output  DATA_W: registered. Broadcast result.

## Operation

- Eligible set: E[i] = Req[i] & ~Ack[i]. A station acked in the current cycle is masked at the next edge, so one result is never broadcast twice.
- Pointer Ptr ranges 0..N_RS-1 and marks the highest-priority index. Search order is Ptr, Ptr+1, …, wrapping modulo N_RS.
- At each rising edge with Reset high and Hold_CDB low:
  - If E is non-zero: winner w = first eligible index in search order.
    - Ack <= onehot(w), CDB_Valid <= 1, CDB_Tag <= w+1, CDB_Data <= Req_Data[w].
    - Ptr <= (w+1) mod N_RS. Compute the wrap explicitly; N_RS is not a power of two.
  - If E is zero: Ack <= 0, CDB_Valid <= 0, CDB_Tag <= 0, CDB_Data <= 16'hFFF0 (the "no value" constant). Ptr is unchanged.
- Hold_CDB high: same as E zero. Ptr is unchanged; requests stay pending.
- Requester handshake:
  - Raise Req[i] with the data valid.
  - Keep both stable until Ack[i] is seen high.
  - Drop Req[i] (or present a new result) by the next edge.
  - A requester never drops Req before Ack. Behaviour in that case is undefined.
- Fairness: with all N_RS requesting continuously, each station is granted once every N_RS cycles. Worst-case wait is N_RS cycles from Req, excluding Hold_CDB cycles.
- A Req asserted in the same cycle as a grant to another station competes at the next edge under the updated Ptr.

## Timing

- Latency: Req[i] sampled high at edge k with i the winner gives Ack[i]/CDB_Valid high from edge k to edge k+1. That is one cycle, fully registered, with no combinational path from Req to outputs.
- Throughput: one broadcast per cycle while at least one other station is eligible. A lone station can win at most every other cycle because of the Ack mask.
- Reset (Reset low at an edge): Ack = 0, CDB_Valid = 0, CDB_Tag = 0, CDB_Data = 16'hFFF0, Ptr = 0.
  - Applies even mid-broadcast; the in-flight broadcast is dropped.
  - Requesters must re-request after reset.
- Reset has priority over Hold_CDB and Req.
- Simultaneous Hold_CDB rising and Ack high: the current broadcast completes this cycle. The next edge produces an idle cycle.

## Structure

- Shared package pacote_tomasulo holds:
  - TAG_W.
  - Tag constants FREE_REGISTER = 0, RES_STATION_ADD1 = 1, RES_STATION_ADD2 = 2, RES_STATION_MUL1 = 3.
  - VALOR_VAZIO = 16'hFFF0.
  - These constants are also consumed by the dispatch unit and the register status table.
- Sub-module seletor_round_robin: combinational. Takes (E, Ptr) and produces (found, w) with circular priority search. Parameterized by N_RS.
- Ptr, Ack and the CDB output registers live in arbitro_cdb.

## Test plan

- Reset: drive Reset=0 for 2 cycles with Req=3'b111 -> Ack=0, CDB_Valid=0, CDB_Tag=0, CDB_Data=16'hFFF0. First grant after release goes to index 0 (Tag 1).
- Single request: Req[1]=1, data 16'h0042 -> one cycle later Ack=3'b010, CDB_Tag=2, CDB_Data=16'h0042. Drop Req -> next cycle CDB_Valid=0.
- Full contention: Req=3'b111 held, each station drops and re-raises after its Ack, data 16'h0011/0022/0033 -> CDB_Tag sequence 1,2,3,1,2,3, no idle cycles.
- Ack mask: only Req[0] held continuously, never dropped -> Tag 1 on alternate cycles, CDB_Valid pattern 1,0,1,0. Never two consecutive grants.
- Hold_CDB: Req=3'b110, Hold_CDB=1 for 3 cycles -> CDB_Valid=0 and Ack=0 throughout, Ptr unchanged. After release: Tag 2, then Tag 3.
- Reset mid-operation: Reset=0 in the cycle where CDB_Valid=1, Tag=3 -> next cycle all outputs at reset values and Ptr=0. With Req=3'b101 after release, the grant goes to Tag 1.
